// File: rtl/vga_timing_gen.sv
// VGA raster timing: position, display enable and active-low syncs, all registered from the next position on each pix_ce edge.
// No backpressure; pix_ce qualifies advance. VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        frame_start,
  output logic        line_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
  // Boundaries held at 11 bits so a 1024-wide total still compares correctly
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc, vc;
  logic [9:0] hc_next, vc_next;
  logic       blank_next, hs_next, vs_next;
  logic       line_next, frame_next;

  always_comb begin
    hc_next = (hc == H_MAX) ? 10'd0 : hc + 10'd1;
    vc_next = vc;
    if (hc == H_MAX) begin
      vc_next = (vc == V_MAX) ? 10'd0 : vc + 10'd1;
    end
    blank_next = ({1'b0, hc_next} < H_VIS) && ({1'b0, vc_next} < V_VIS);
    hs_next    = !(({1'b0, hc_next} >= HS_START) && ({1'b0, hc_next} < HS_END));
    vs_next    = !(({1'b0, vc_next} >= VS_START) && ({1'b0, vc_next} < VS_END));
    line_next  = (hc_next == 10'd0);
    frame_next = line_next && (vc_next == 10'd0);
  end

  // Counters start at the last position so the first advance presents (0,0)
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= H_MAX;
      vc          <= V_MAX;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      blank       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (pix_ce) begin
        hc          <= hc_next;
        vc          <= vc_next;
        DrawX       <= hc_next;
        DrawY       <= vc_next;
        blank       <= blank_next;
        hs          <= hs_next;
        vs          <= vs_next;
        frame_start <= frame_next;
        line_start  <= line_next;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 16'd0;
    end else if (pix_ce && frame_next) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen on a reduced raster (32x17) so whole frames fit the run.
module tb_vga_timing_gen;

  localparam int HV = 20, HF = 3, HS = 5, HB = 4;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pix_ce  = 1'b0;
  logic [9:0]  DrawX, DrawY;
  logic        blank, hs, vs, frame_start, line_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .frame_start (frame_start),
    .line_start  (line_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        ls;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc;
`endif
  } obs_t;

  obs_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   p      = -1;   // raster index of the presented pixel; -1 = nothing since reset
  int   frames = 0;    // frame_start pulses since reset

  function automatic obs_t reset_obs();
    obs_t o;
    o    = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    return o;
  endfunction

  // Position is the raster index split into line/column; decode straight from the timing table
  function automatic obs_t model(input int pos, input bit pulse, input int nfr);
    obs_t o;
    int   x, y;
    x       = pos % HT;
    y       = (pos / HT) % VT;
    o       = '0;
    o.x     = 10'(x);
    o.y     = 10'(y);
    o.blank = (x < HV) && (y < VV);
    o.hs    = !((x >= HV + HF) && (x < HV + HF + HS));
    o.vs    = !((y >= VV + VF) && (y < VV + VF + VS));
    o.ls    = pulse && (x == 0);
    o.fs    = pulse && (x == 0) && (y == 0);
`ifdef VGA_FRAME_COUNT_EN
    o.fc    = 16'(nfr % 65536);
`endif
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o       = '0;
    o.x     = DrawX;
    o.y     = DrawY;
    o.blank = blank;
    o.hs    = hs;
    o.vs    = vs;
    o.fs    = frame_start;
    o.ls    = line_start;
`ifdef VGA_FRAME_COUNT_EN
    o.fc    = frame_count;
`endif
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b ls=%b (%h) want x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b ls=%b (%h)",
               name, $time, act.x, act.y, act.blank, act.hs, act.vs, act.fs, act.ls, act,
               exp.x, exp.y, exp.blank, exp.hs, exp.vs, exp.fs, exp.ls, exp);
    end
  endtask

  // Called at a falling edge: drive pix_ce, predict the next rising edge, wait one clock
  task automatic step(input bit ce);
    bit pulse;
    pix_ce = ce;
    pulse  = reset_n && ce;
    if (pulse) begin
      p++;
      if ((p % HT == 0) && ((p / HT) % VT == 0)) frames++;
    end
    if (p < 0) q.push_back(reset_obs());
    else       q.push_back(model(p, pulse, frames));
    @(negedge vga_clk);
  endtask

  // Asynchronous reset away from any clock edge; outputs must react before the next edge
  task automatic do_reset(input int hold);
    q.push_back(reset_obs());
    p      = -1;
    frames = 0;
    #2 reset_n = 1'b0;
    #1 check("async_reset", sample(), reset_obs());
    @(negedge vga_clk);
    repeat (hold) step(1'($urandom_range(0, 1)));
    reset_n = 1'b1;
  endtask

  initial begin
    forever begin
      obs_t e;
      @(posedge vga_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("raster", sample(), e);
      end
    end
  end

  initial begin
    #1 reset_n = 1'b0;
    #1 check("reset_state", sample(), reset_obs());
    @(negedge vga_clk);
    step(1'b1);
    step(1'b0);
    reset_n = 1'b1;

    // Continuous advance: two full frames plus a line, covers every sync/blank boundary and wrap
    repeat (2 * HT * VT + HT) step(1'b1);

    // Half-rate advance
    for (int i = 0; i < 2 * HT * VT + 10; i++) step(i % 2 == 0);

    // Reset in the middle of a frame, then restart
    repeat (5 * HT + 7) step(1'b1);
    do_reset(2);
    repeat (3) step(1'b0);

    // Random pix_ce duty with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset($urandom_range(0, 3));
      else                             step($urandom_range(0, 3) != 0);
    end
    do_reset(1);
    repeat (HT * VT + 3) step($urandom_range(0, 1) == 1);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge vga_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
